// File: rtl/wb_bus_scheduler.sv
// Registered round-robin scheduler for the shared wishbone bus.
// Grants one master at a time, caps each tenure at MAX_XFER acks when other
// masters are waiting, and kills a hung access with a one-cycle timeout pulse.
module wb_bus_scheduler #(
  parameter int MASTER_NUM  = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_XFER    = 8,
  localparam int GW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int TW = $clog2(TIMEOUT_CYC + 1),
  localparam int XW = (MAX_XFER > 0) ? $clog2(MAX_XFER + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_NUM-1:0] master_cyc_i_array,
  input  logic [MASTER_NUM-1:0] master_stb_i_array,
  input  logic                  any_slave_ack,
  input  logic                  any_slave_err,
  input  logic                  any_slave_rty,
  output logic [MASTER_NUM-1:0] master_grant_onehot,
  output logic [GW-1:0]         master_grant_bcd,
  output logic [MASTER_NUM-1:0] master_timeout_o_array,
  output logic                  bus_busy_o
);

  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT_CYC);
  localparam logic [XW-1:0] XF_MAX = XW'(MAX_XFER);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TOUT, S_GAP} state_t;

  state_t                r_state, w_state_nx;
  logic [MASTER_NUM-1:0] r_grant, w_grant_nx;
  logic [MASTER_NUM-1:0] r_tout, w_tout_nx;
  logic [GW-1:0]         r_bcd, w_bcd_nx;
  logic [GW-1:0]         r_rr_ptr, w_rr_nx;
  logic [TW-1:0]         r_wd_cnt, w_wd_nx, w_wd_inc;
  logic [XW-1:0]         r_xfer_cnt, w_xfer_nx, w_xfer_inc;
  logic                  r_busy;

  logic [GW-1:0]         w_pick;
  logic [MASTER_NUM-1:0] w_pick_oh;
  logic                  w_pick_vld;
  logic                  w_rsp, w_gstb, w_gcyc, w_others;

  assign w_rsp    = any_slave_ack | any_slave_err | any_slave_rty;
  assign w_gstb   = |(r_grant & master_stb_i_array);
  assign w_gcyc   = |(r_grant & master_cyc_i_array);
  assign w_others = |(master_cyc_i_array & ~r_grant);

  // Round-robin pick: first requester above rr_ptr, wrapping; last owner ranks last.
  always_comb begin
    w_pick     = '0;
    w_pick_oh  = '0;
    w_pick_vld = 1'b0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      for (int j = 0; j < MASTER_NUM; j++) begin
        if (!w_pick_vld && master_cyc_i_array[j] &&
            (j == (int'(r_rr_ptr) + i) % MASTER_NUM)) begin
          w_pick_vld   = 1'b1;
          w_pick       = GW'(j);
          w_pick_oh[j] = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic; counters default to cleared outside OWN.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_bcd_nx   = r_bcd;
    w_rr_nx    = r_rr_ptr;
    w_tout_nx  = '0;
    w_wd_nx    = '0;
    w_xfer_nx  = '0;
    w_wd_inc   = (r_wd_cnt == WD_MAX) ? WD_MAX : r_wd_cnt + 1'b1;
    w_xfer_inc = (r_xfer_cnt == XF_MAX) ? XF_MAX : r_xfer_cnt + 1'b1;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_grant_nx = '0;
        w_state_nx = S_IDLE;
        if (w_pick_vld) begin
          w_state_nx = S_OWN;
          w_grant_nx = w_pick_oh;
          w_bcd_nx   = w_pick;
          w_rr_nx    = w_pick;
        end
      end
      S_OWN: begin
        w_wd_nx   = (w_rsp || !w_gstb) ? '0 : w_wd_inc;
        w_xfer_nx = any_slave_ack ? w_xfer_inc : r_xfer_cnt;
        // Owner release wins over timeout, timeout wins over quota.
        if (!w_gcyc) begin
          w_state_nx = S_GAP;
          w_grant_nx = '0;
          w_wd_nx    = '0;
          w_xfer_nx  = '0;
        end else if (w_wd_nx == WD_MAX && !w_rsp) begin
          w_state_nx = S_TOUT;
          w_tout_nx  = r_grant;
        end else if ((MAX_XFER != 0) && (w_xfer_nx == XF_MAX) && w_others) begin
          w_state_nx = S_GAP;
          w_grant_nx = '0;
          w_wd_nx    = '0;
          w_xfer_nx  = '0;
        end
      end
      S_TOUT: begin
        w_state_nx = S_GAP;
        w_grant_nx = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_bcd      <= '0;
      r_rr_ptr   <= GW'(MASTER_NUM - 1);
      r_tout     <= '0;
      r_wd_cnt   <= '0;
      r_xfer_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_bcd      <= w_bcd_nx;
      r_rr_ptr   <= w_rr_nx;
      r_tout     <= w_tout_nx;
      r_wd_cnt   <= w_wd_nx;
      r_xfer_cnt <= w_xfer_nx;
      r_busy     <= |w_grant_nx;
    end
  end

  assign master_grant_onehot    = r_grant;
  assign master_grant_bcd       = r_bcd;
  assign master_timeout_o_array = r_tout;
  assign bus_busy_o             = r_busy;

endmodule
